// File: rtl/asynch_clk_div_4.sv
`timescale 1ns/1ps
// Ripple divide-by-4 clock: two cascaded toggle flops, out_clk = f(clk)/4 at 50 % duty.
// Define ASYNCH_CLK_DIV_4_RESYNC_EN to retime the output onto clk (one extra cycle of latency).
module asynch_clk_div_4 (
    input  logic clk,
    input  logic rst_n,
    output logic out_clk
);

    logic q0;
    logic q1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q0 <= 1'b0;
        else        q0 <= ~q0;
    end

    // Clocked on the falling edge of q0 so the {q1,q0} pair counts up.
    always_ff @(negedge q0 or negedge rst_n) begin
        if (!rst_n) q1 <= 1'b0;
        else        q1 <= ~q1;
    end

`ifdef ASYNCH_CLK_DIV_4_RESYNC_EN
    logic q1_r;

    // Samples q1 before the ripple from this same clk edge reaches it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q1_r <= 1'b0;
        else        q1_r <= q1;
    end

    assign out_clk = q1_r;
`else
    assign out_clk = q1;
`endif

endmodule

// File: tb/tb_asynch_clk_div_4.sv
`timescale 1ns/1ps
// Bench for asynch_clk_div_4: table-driven per-edge checks plus
// mid-period reset and duty/frequency sequences.
module tb_asynch_clk_div_4;

`ifdef ASYNCH_CLK_DIV_4_RESYNC_EN
    localparam bit RESYNC = 1'b1;
`else
    localparam bit RESYNC = 1'b0;
`endif

    logic clk;
    logic rst_n;
    logic out_clk;

    int total;
    int bad;

    asynch_clk_div_4 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .out_clk (out_clk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic rst_n;
        logic exp_q0;
        logic exp_q1;
    } vec_t;

    vec_t vecs[$];
    logic prev_q1;

    task automatic check(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %b want %b", name, $time, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic q0, input logic q1);
        vec_t v;
        v.rst_n  = r;
        v.exp_q0 = q0;
        v.exp_q1 = q1;
        vecs.push_back(v);
    endtask

    task automatic add_run(input int n);
        // Counting sequence 01,10,11,00 ... from a cleared state.
        for (int k = 1; k <= n; k++)
            add(1'b1, logic'(k % 2), logic'(((k % 4) == 2) || ((k % 4) == 3)));
    endtask

    // Duty/frequency measurement on every out_clk transition.
    bit   meas;
    bit   have_last;
    time  last_t;
    int   rises;

    always @(out_clk) begin
        if (meas) begin
            if (have_last) begin
                total++;
                if ($time - last_t != 20) begin
                    bad++;
                    $display("FAIL interval at %0t: got %0t ns want 20 ns", $time, $time - last_t);
                end
            end
            have_last = 1'b1;
            last_t    = $time;
            if (out_clk === 1'b1) rises++;
        end
    end

    initial begin
        logic exp_out;
        int   first_rise;
        total     = 0;
        bad       = 0;
        meas      = 1'b0;
        have_last = 1'b0;
        rises     = 0;
        rst_n     = 1'b0;
        prev_q1   = 1'b0;

        // Power-up reset, release, two full periods, long reset, restart.
        add(1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0);
        add_run(8);
        for (int k = 0; k < 17; k++) add(1'b0, 1'b0, 1'b0);
        add_run(4);

        #1;
        check("reset_out_t0", out_clk, 1'b0);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst_n = vecs[i].rst_n;
            @(posedge clk);
            #1;
            exp_out = RESYNC ? prev_q1 : vecs[i].exp_q1;
            prev_q1 = vecs[i].rst_n ? vecs[i].exp_q1 : 1'b0;
            check($sformatf("vec%0d_q0", i), dut.q0, vecs[i].exp_q0);
            check($sformatf("vec%0d_out", i), out_clk, exp_out);
        end

        // Three more edges: state 11, out_clk high in both builds.
        repeat (3) @(posedge clk);
        #1;
        check("pre_midreset_out", out_clk, 1'b1);

        // Mid-period reset must clear immediately, without a clk edge.
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_out", out_clk, 1'b0);
        check("midreset_q0", dut.q0, 1'b0);
        @(negedge clk);
        check("midreset_hold_out", out_clk, 1'b0);
        rst_n = 1'b1;

        first_rise = RESYNC ? 3 : 2;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("restart_e%0d_out", k), out_clk,
                  logic'((k >= first_rise && k < first_rise + 2) ||
                         (k >= first_rise + 4)));
            check($sformatf("restart_e%0d_q0", k), dut.q0, logic'(k % 2));
        end

        // 100 clk cycles -> exactly 25 rising edges, every interval 20 ns.
        meas = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        meas = 1'b0;
        total++;
        if (rises != 25) begin
            bad++;
            $display("FAIL rise_count: got %0d want 25", rises);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
